// File: rtl/mnist_frame_feeder.sv
// ---------------------------------------------------------------------------
// mnist_frame_feeder
//
// Buffers one MNIST frame written by a host in raster order, streams it to a
// CNN one pixel per cycle on request, then waits for the CNN's class decision
// (or gives up after TIMEOUT cycles) and holds the result until the host
// acknowledges it.
//
// Parameters
//   NUM_PIXELS   pixels per frame (28x28 = 784)
//   PIXEL_BITS   width of one pixel
//   TIMEOUT      WAIT cycles before the result is abandoned
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset
//   wr_en        host pixel write strobe (IDLE only, until the buffer is full)
//   wr_data      host pixel
//   start        host request to stream the loaded frame
//   cnn_decision class reported by the CNN
//   cnn_valid    CNN decision-valid pulse (honoured in WAIT only)
//   res_ack      host result acknowledge (honoured in DONE only)
//   in_data      pixel stream to the CNN
//   stream_valid high on every cycle in_data carries a frame pixel
//   loaded       full frame is buffered
//   busy         streaming or waiting for the CNN
//   res_valid    result available
//   res_class    result class (4'hF on timeout)
//   res_timeout  result was produced by the timeout
// ---------------------------------------------------------------------------
module mnist_frame_feeder #(
  parameter int NUM_PIXELS = 784,
  parameter int PIXEL_BITS = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [PIXEL_BITS-1:0] wr_data,
  input  logic                  start,
  input  logic [3:0]            cnn_decision,
  input  logic                  cnn_valid,
  input  logic                  res_ack,
  output logic [PIXEL_BITS-1:0] in_data,
  output logic                  stream_valid,
  output logic                  loaded,
  output logic                  busy,
  output logic                  res_valid,
  output logic [3:0]            res_class,
  output logic                  res_timeout
);

  // Pointers need to reach NUM_PIXELS itself (the "full"/"done" value),
  // while the memory index only needs to cover 0..NUM_PIXELS-1.
  localparam int PTR_W = $clog2(NUM_PIXELS + 1);
  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [PIXEL_BITS-1:0] in_data_q, in_data_d;
  logic                  stream_valid_q, stream_valid_d;
  logic                  res_valid_q, res_valid_d;
  logic [3:0]            res_class_q, res_class_d;
  logic                  res_timeout_q, res_timeout_d;
  logic                  mem_we;

  logic [PIXEL_BITS-1:0] pix_mem_q [NUM_PIXELS];

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             full;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign full   = (wr_ptr_q == FULL_PTR);

  // Frame buffer: deliberately not reset, its contents are don't-care until
  // the host rewrites them, and this keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      pix_mem_q[wr_idx] <= wr_data;
    end
  end

  // State and output registers, all cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wait_cnt_q     <= '0;
      in_data_q      <= '0;
      stream_valid_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_class_q    <= 4'h0;
      res_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wait_cnt_q     <= wait_cnt_d;
      in_data_q      <= in_data_d;
      stream_valid_q <= stream_valid_d;
      res_valid_q    <= res_valid_d;
      res_class_q    <= res_class_d;
      res_timeout_q  <= res_timeout_d;
    end
  end

  // Next-state logic. STREAM lasts NUM_PIXELS+1 cycles: one per pixel read
  // plus a final cycle where rd_ptr has run off the end, which drops
  // stream_valid and hands over to WAIT on the same edge. That way
  // stream_valid is never high outside STREAM despite being registered.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    wait_cnt_d     = wait_cnt_q;
    in_data_d      = '0;
    stream_valid_d = 1'b0;
    res_valid_d    = res_valid_q;
    res_class_d    = res_class_q;
    res_timeout_d  = res_timeout_q;
    mem_we         = 1'b0;

    case (state_q)
      IDLE: begin
        // Start wins over a coincident write; the buffer is full anyway.
        if (start && full) begin
          state_d  = STREAM;
          rd_ptr_d = '0;
        end else if (wr_en && !full) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
      end

      STREAM: begin
        if (rd_ptr_q != FULL_PTR) begin
          in_data_d      = pix_mem_q[rd_idx];
          stream_valid_d = 1'b1;
          rd_ptr_d       = rd_ptr_q + PTR_W'(1);
        end else begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end

      WAIT: begin
        // A decision arriving on the timeout cycle still counts.
        if (cnn_valid) begin
          state_d       = DONE;
          res_valid_d   = 1'b1;
          res_class_d   = cnn_decision;
          res_timeout_d = 1'b0;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d       = DONE;
          res_valid_d   = 1'b1;
          res_class_d   = 4'hF;
          res_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (res_ack) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          wr_ptr_d    = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_data      = in_data_q;
  assign stream_valid = stream_valid_q;
  assign loaded       = full;
  assign busy         = (state_q == STREAM) || (state_q == WAIT);
  assign res_valid    = res_valid_q;
  assign res_class    = res_class_q;
  assign res_timeout  = res_timeout_q;

endmodule

// File: tb/tb_mnist_frame_feeder.sv
// ---------------------------------------------------------------------------
// tb_mnist_frame_feeder
//
// Self-checking bench for mnist_frame_feeder. Two instances share one clock
// and reset: dutA uses the default 784-pixel / 4096-cycle configuration,
// dutB a 16-pixel / 16-cycle-timeout one so timeouts are quick to reach.
// 'sel' chooses which instance receives the stimulus and is observed; the
// other one sees idle inputs. The reference model is a plain array of
// expected pixels plus a write count, with the expected result worked out
// from the decision delay versus the timeout.
// ---------------------------------------------------------------------------
module tb_mnist_frame_feeder;

  localparam int NA = 784;
  localparam int TA = 4096;
  localparam int NB = 16;
  localparam int TB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       wrEn;
  logic [7:0] wrData;
  logic       start;
  logic [3:0] cnnDecision;
  logic       cnnValid;
  logic       resAck;

  logic [7:0] aInData, bInData, inData;
  logic       aStreamValid, bStreamValid, streamValid;
  logic       aLoaded, bLoaded, loaded;
  logic       aBusy, bBusy, busy;
  logic       aResValid, bResValid, resValid;
  logic [3:0] aResClass, bResClass, resClass;
  logic       aResTimeout, bResTimeout, resTimeout;

  int vectors     = 0;
  int miscompares = 0;

  int modelBuf [NA];
  int modelPtr = 0;

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  mnist_frame_feeder #(
    .NUM_PIXELS(NA),
    .PIXEL_BITS(8),
    .TIMEOUT   (TA)
  ) dutA (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wrEn & ~sel),
    .wr_data     (wrData),
    .start       (start & ~sel),
    .cnn_decision(cnnDecision),
    .cnn_valid   (cnnValid & ~sel),
    .res_ack     (resAck & ~sel),
    .in_data     (aInData),
    .stream_valid(aStreamValid),
    .loaded      (aLoaded),
    .busy        (aBusy),
    .res_valid   (aResValid),
    .res_class   (aResClass),
    .res_timeout (aResTimeout)
  );

  mnist_frame_feeder #(
    .NUM_PIXELS(NB),
    .PIXEL_BITS(8),
    .TIMEOUT   (TB)
  ) dutB (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wrEn & sel),
    .wr_data     (wrData),
    .start       (start & sel),
    .cnn_decision(cnnDecision),
    .cnn_valid   (cnnValid & sel),
    .res_ack     (resAck & sel),
    .in_data     (bInData),
    .stream_valid(bStreamValid),
    .loaded      (bLoaded),
    .busy        (bBusy),
    .res_valid   (bResValid),
    .res_class   (bResClass),
    .res_timeout (bResTimeout)
  );

  // Observe whichever instance is currently selected
  assign inData      = sel ? bInData      : aInData;
  assign streamValid = sel ? bStreamValid : aStreamValid;
  assign loaded      = sel ? bLoaded      : aLoaded;
  assign busy        = sel ? bBusy        : aBusy;
  assign resValid    = sel ? bResValid    : aResValid;
  assign resClass    = sel ? bResClass    : aResClass;
  assign resTimeout  = sel ? bResTimeout  : aResTimeout;

  function automatic int curN();
    return sel ? NB : NA;
  endfunction

  function automatic int curTimeout();
    return sel ? TB : TA;
  endfunction

  // Single comparison point: counts every vector, reports any miscompare
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then return the
  // inputs to idle. Outputs are sampled 1 unit after the edge by callers.
  task automatic applyStimulus(input logic we, input logic [7:0] d,
                               input logic st, input logic cv,
                               input logic [3:0] dec, input logic ack);
    wrEn        = we;
    wrData      = d;
    start       = st;
    cnnValid    = cv;
    cnnDecision = dec;
    resAck      = ack;
    @(posedge clk);
    #1;
    wrEn        = 1'b0;
    wrData      = 8'h00;
    start       = 1'b0;
    cnnValid    = 1'b0;
    cnnDecision = 4'h0;
    resAck      = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".inData"},      inData,      0);
    checkOutput({tag, ".streamValid"}, streamValid, 0);
    checkOutput({tag, ".loaded"},      loaded,      0);
    checkOutput({tag, ".busy"},        busy,        0);
    checkOutput({tag, ".resValid"},    resValid,    0);
    checkOutput({tag, ".resClass"},    resClass,    0);
    checkOutput({tag, ".resTimeout"},  resTimeout,  0);
  endtask

  // Reset both instances and select one for the following tests
  task automatic doReset(input logic which);
    sel = which;
    rst = 1'b0;
    #2;
    checkResetOutputs("reset");
    @(negedge clk);
    rst      = 1'b1;
    modelPtr = 0;
  endtask

  task automatic writePixel(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 4'h0, 1'b0);
    if (modelPtr < curN()) begin
      modelBuf[modelPtr] = d;
      modelPtr++;
    end
    checkOutput("loaded", loaded, (modelPtr == curN()));
  endtask

  // Start the stream and check every pixel against the model. With noise
  // set, random writes/starts/decisions are thrown at the DUT during STREAM
  // and must be ignored. abortAt >= 0 pulls reset after that pixel.
  task automatic streamFrame(input int abortAt, input bit noise);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
    checkOutput("busyAtStart", busy, 1);
    checkOutput("svAtStart", streamValid, 0);
    for (int i = 0; i < curN(); i++) begin
      if (noise) begin
        applyStimulus(logic'($urandom_range(0, 1)), 8'($urandom),
                      logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                      4'($urandom), logic'($urandom_range(0, 1)));
      end else begin
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
      end
      checkOutput("streamValid", streamValid, 1);
      checkOutput("inData", inData, modelBuf[i]);
      if (i == abortAt) begin
        rst = 1'b0;
        #1;
        checkResetOutputs("midStreamReset");
        @(negedge clk);
        rst      = 1'b1;
        modelPtr = 0;
        for (int j = 0; j < 4; j++) begin
          applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
          checkOutput("svAfterReset", streamValid, 0);
          checkOutput("busyAfterReset", busy, 0);
        end
        return;
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("svEnd", streamValid, 0);
    checkOutput("busyInWait", busy, 1);
  endtask

  // From the first WAIT cycle: the decision arrives in WAIT cycle 'delay'
  // (counting from 0); delays at or beyond the timeout mean it never comes.
  // Then hold in DONE under noise and acknowledge.
  task automatic runResult(input int delay, input logic [3:0] dec,
                           input bit ackNoise, input int holdCycles);
    bit         done = 0;
    bit         expTimeout;
    logic [3:0] expClass;
    logic       cv;
    expTimeout = (delay >= curTimeout());
    expClass   = expTimeout ? 4'hF : dec;
    for (int k = 0; k < curTimeout() && !done; k++) begin
      cv = (k == delay);
      applyStimulus(1'b0, 8'h00, 1'b0, cv, dec,
                    ackNoise ? logic'($urandom_range(0, 1)) : 1'b0);
      if (cv || k == curTimeout() - 1) begin
        done = 1;
      end else begin
        checkOutput("resValidInWait", resValid, 0);
        checkOutput("busyInWait", busy, 1);
      end
    end
    checkOutput("resValid", resValid, 1);
    checkOutput("resClass", resClass, expClass);
    checkOutput("resTimeout", resTimeout, expTimeout);
    checkOutput("busyDone", busy, 0);
    for (int h = 0; h < holdCycles; h++) begin
      applyStimulus(logic'($urandom_range(0, 1)), 8'($urandom),
                    logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                    4'($urandom), 1'b0);
      checkOutput("resValidHold", resValid, 1);
      checkOutput("resClassHold", resClass, expClass);
      checkOutput("resTimeoutHold", resTimeout, expTimeout);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1);
    modelPtr = 0;
    checkOutput("resValidAfterAck", resValid, 0);
    checkOutput("loadedAfterAck", loaded, 0);
    checkOutput("busyAfterAck", busy, 0);
    // With nothing loaded a start must not begin a stream
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
    checkOutput("busyStartUnloaded", busy, 0);
  endtask

  initial begin
    sel         = 1'b0;
    wrEn        = 1'b0;
    wrData      = 8'h00;
    start       = 1'b0;
    cnnDecision = 4'h0;
    cnnValid    = 1'b0;
    resAck      = 1'b0;
    rst         = 1'b0;

    // Full-size frame, counting pattern, decision 7 after 100 WAIT cycles
    doReset(1'b0);
    for (int i = 0; i < NA; i++) writePixel(8'(i % 256));
    streamFrame(-1, 1'b0);
    runResult(100, 4'd7, 1'b1, 5);

    // Start before the frame is complete is ignored; writes past full too
    for (int i = 0; i < 500; i++) writePixel(8'($urandom));
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
      checkOutput("busyPartial", busy, 0);
      checkOutput("svPartial", streamValid, 0);
    end
    for (int i = 500; i < NA; i++) writePixel(8'($urandom));
    writePixel(8'($urandom));
    writePixel(8'($urandom));
    streamFrame(-1, 1'b1);
    runResult($urandom_range(0, 200), 4'($urandom), 1'b1, 3);

    // Reset pulled in the middle of a stream
    for (int i = 0; i < NA; i++) writePixel(8'($urandom));
    streamFrame(300, 1'b0);
    checkOutput("loadedAfterAbort", loaded, 0);

    // Small instance: pure timeout, decision on the timeout cycle, immediate
    doReset(1'b1);
    for (int i = 0; i < NB; i++) writePixel(8'($urandom));
    streamFrame(-1, 1'b1);
    runResult(TB + 100, 4'd3, 1'b1, 2);
    for (int i = 0; i < NB; i++) writePixel(8'($urandom));
    streamFrame(-1, 1'b0);
    runResult(TB - 1, 4'd9, 1'b0, 2);
    for (int i = 0; i < NB; i++) writePixel(8'($urandom));
    streamFrame(-1, 1'b1);
    runResult(0, 4'd5, 1'b0, 1);

    // Randomized rounds, some decisions landing past the timeout
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NB + int'($urandom_range(0, 2)); i++) writePixel(8'($urandom));
      streamFrame(-1, 1'b1);
      runResult($urandom_range(0, TB + 8), 4'($urandom), 1'b1, $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mnist_frame_feeder.md
MNIST_FRAME_FEEDER -- requirements
Module: mnist_frame_feeder

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 784, giving the pixels per frame (28x28).
REQ-002 SHALL have parameter PIXEL_BITS, default 8, giving the pixel width.
REQ-003 SHALL have parameter TIMEOUT, default 4096, giving the maximum number of WAIT cycles before the result is abandoned.
REQ-004 SHALL have port clk, input, 1, as the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst, input, 1, as the reset: asynchronous, active-low.
REQ-006 SHALL have port wr_en, input, 1, as the host pixel write strobe.
REQ-007 SHALL have port wr_data, input, PIXEL_BITS, as the host pixel, written in raster order.
REQ-008 SHALL have port start, input, 1, as the host request to stream the loaded frame.
REQ-009 SHALL have port cnn_decision, input, 4, as the class from the CNN.
REQ-010 SHALL have port cnn_valid, input, 1, as the CNN decision-valid pulse.
REQ-011 SHALL have port in_data, output, PIXEL_BITS, as the pixel stream to the CNN.
REQ-012 SHALL have port stream_valid, output, 1, high on every cycle in_data carries a frame pixel.
REQ-013 SHALL have port loaded, output, 1, high when NUM_PIXELS pixels are buffered.
REQ-014 SHALL have port busy, output, 1, high in STREAM or WAIT.
REQ-015 SHALL have port res_valid, output, 1, as the result-available flag.
REQ-016 SHALL have port res_class, output, 4, as the result class.
REQ-017 SHALL have port res_timeout, output, 1, as the result-timed-out flag.
REQ-018 SHALL have port res_ack, input, 1, as the host result acknowledge.

Function
REQ-019 SHALL implement an FSM with the states IDLE, STREAM, WAIT and DONE.
REQ-020 SHALL, in IDLE with wr_en=1 and wr_ptr<NUM_PIXELS, store wr_data at buf[wr_ptr] and increment wr_ptr; loaded SHALL equal (wr_ptr==NUM_PIXELS).
REQ-021 SHALL ignore wr_en when the buffer is full or the FSM is not in IDLE, leaving the buffer and wr_ptr unchanged.
REQ-022 SHALL accept start only in IDLE with loaded=1, going to STREAM with rd_ptr=0; start in any other case SHALL be ignored.
REQ-023 SHALL ignore wr_en in the cycle start is accepted.
REQ-024 SHALL, in STREAM, register buf[rd_ptr] onto in_data with stream_valid=1 each cycle, so that start accepted at edge T yields pixel 0 after edge T+1 and pixel NUM_PIXELS-1 after edge T+NUM_PIXELS, with no gaps.
REQ-025 SHALL drive in_data=0 and stream_valid=0 outside STREAM.
REQ-026 SHALL enter WAIT after the last pixel and clear a wait counter.
REQ-027 SHALL, in WAIT, increment the wait counter each cycle.
REQ-028 SHALL, in WAIT, on cnn_valid=1 register res_class=cnn_decision and res_timeout=0 and go to DONE, with res_valid=1 on the next cycle.
REQ-029 SHALL, in WAIT, when the counter reaches TIMEOUT-1 without cnn_valid, set res_class=4'hF and res_timeout=1 and go to DONE.
REQ-030 SHALL give cnn_valid priority when it coincides with the timeout cycle.
REQ-031 SHALL ignore cnn_valid in IDLE, STREAM and DONE.
REQ-032 SHALL, in DONE, hold res_valid=1, res_class and res_timeout stable until res_ack=1.
REQ-033 SHALL, on res_ack=1 in DONE, go to IDLE, clear res_valid and wr_ptr (loaded=0), and retain buffer contents.
REQ-034 SHALL ignore res_ack outside DONE.

Reset
REQ-035 SHALL, with rst=0 at any time including mid-STREAM or mid-WAIT, immediately force IDLE, wr_ptr=0, rd_ptr=0, wait counter=0, in_data=0, stream_valid=0, loaded=0, busy=0, res_valid=0, res_class=0 and res_timeout=0.
REQ-036 SHALL not reset the buffer contents, which are don't-care until rewritten.
REQ-037 SHALL resume operation on the first rising clk edge after rst returns high.

Verification
REQ-038 SHALL be verified by writing pixels 0..783 as (i mod 256) then pulsing start, requiring stream_valid high for exactly 784 consecutive cycles, in_data sequence 0,1,...,255,0,..., and the first pixel one cycle after start.
REQ-039 SHALL be verified by asserting cnn_valid with cnn_decision=7 100 cycles into WAIT, requiring res_valid=1 next cycle with res_class=7 and res_timeout=0 held until res_ack, then IDLE with loaded=0.
REQ-040 SHALL be verified with TIMEOUT=16 and no cnn_valid, requiring res_valid after 16 WAIT cycles with res_class=4'hF and res_timeout=1; cnn_valid on the timeout cycle SHALL instead yield its class with res_timeout=0.
REQ-041 SHALL be verified by pulsing start after 500 writes, requiring no stream and busy=0; a 785th write SHALL leave the buffer unchanged.
REQ-042 SHALL be verified by pulsing rst=0 at pixel 300 of STREAM, requiring all outputs at reset values without waiting for a clock edge and stream_valid to stay 0 afterwards.
REQ-043 SHALL be verified by asserting cnn_valid during STREAM and res_ack during WAIT, requiring both to be ignored with no result change.
